// File: rtl/traceback_engine_if.sv
// Alignment op stream from the traceback engine to its consumer.
interface traceback_engine_if #(
  parameter int unsigned IDX_W = 3
);
  logic             op_valid;
  logic             op_ready;
  logic [1:0]       op_code;
  logic [IDX_W-1:0] op_row;
  logic [IDX_W-1:0] op_col;
  logic             op_last;

  modport master (
    output op_valid,
    output op_code,
    output op_row,
    output op_col,
    output op_last,
    input  op_ready
  );

  modport slave (
    input  op_valid,
    input  op_code,
    input  op_row,
    input  op_col,
    input  op_last,
    output op_ready
  );
endinterface

// File: rtl/traceback_engine.sv
// Sequential DP traceback: walks a row-major score matrix held in a single-port
// synchronous RAM from a start cell toward the origin, streaming one op per step.
module traceback_engine #(
  parameter int unsigned ROWS    = 8,
  parameter int unsigned COLS    = 8,
  parameter int unsigned SCORE_W = 16,
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned IDX_W   = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [IDX_W-1:0]          start_row,
  input  logic [IDX_W-1:0]          start_col,
  input  logic                      local_mode,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [IDX_W:0]            op_count,
  output logic                      mem_rd_en,
  output logic [ADDR_W-1:0]         mem_addr,
  input  logic signed [SCORE_W-1:0] mem_rdata,
  traceback_engine_if.master        op
);

  localparam logic [1:0] OpDiag = 2'b00;
  localparam logic [1:0] OpTop  = 2'b01;
  localparam logic [1:0] OpLeft = 2'b10;

  typedef enum logic [3:0] {
    StIdle,
    StRdC,
    StChk,
    StRdD,
    StRdT,
    StRdL,
    StCap,
    StDecide,
    StEmit,
    StFin
  } state_e;

  state_e state_q, state_d;

  logic [IDX_W-1:0]          row_q, col_q;
  logic                      lmode_q;
  logic signed [SCORE_W-1:0] cur_q, diag_q, top_q, left_q;
  logic                      err_q;
  logic [IDX_W:0]            cnt_q;

  // Registered op and the cell it leads to.
  logic [1:0]                code_q;
  logic [IDX_W-1:0]          orow_q, ocol_q;
  logic                      last_q;
  logic [IDX_W-1:0]          nrow_q, ncol_q;
  logic signed [SCORE_W-1:0] nscore_q;

  logic                      start_oor;
  logic                      chk_term, chk_bound, next_bound;
  logic [1:0]                dec_code;
  logic [IDX_W-1:0]          dec_row, dec_col;
  logic signed [SCORE_W-1:0] dec_score;
  logic                      dec_last;
  logic [IDX_W-1:0]          addr_row, addr_col;

  // Terminal-cell test shared by CHK and the op_last lookahead.
  function automatic logic is_terminal(input logic [IDX_W-1:0]          r,
                                       input logic [IDX_W-1:0]          c,
                                       input logic signed [SCORE_W-1:0] s,
                                       input logic                      lm);
    if (lm) begin
      return s[SCORE_W-1] || (s == '0) || (r == '0) || (c == '0);
    end
    return (r == '0) && (c == '0);
  endfunction

  // Start coordinate range check and terminal/boundary routing.
  always_comb begin
    start_oor  = (32'(start_row) >= ROWS) || (32'(start_col) >= COLS);
    // CHK is only entered straight after RD_C, so the start score is on mem_rdata.
    chk_term   = is_terminal(row_q, col_q, mem_rdata, lmode_q);
    chk_bound  = !lmode_q && ((row_q == '0) || (col_q == '0));
    next_bound = !lmode_q && ((nrow_q == '0) || (ncol_q == '0));
  end

  // Predecessor selection: boundary cells are forced, interior takes the max.
  always_comb begin
    dec_code  = OpDiag;
    dec_row   = row_q - IDX_W'(1);
    dec_col   = col_q - IDX_W'(1);
    dec_score = diag_q;
    if (row_q == '0) begin
      dec_code  = OpLeft;
      dec_row   = row_q;
      dec_score = cur_q;
    end else if (col_q == '0) begin
      dec_code  = OpTop;
      dec_col   = col_q;
      dec_score = cur_q;
    end else if ((diag_q >= top_q) && (diag_q >= left_q)) begin
      dec_code  = OpDiag;
    end else if (top_q >= left_q) begin
      dec_code  = OpTop;
      dec_col   = col_q;
      dec_score = top_q;
    end else begin
      dec_code  = OpLeft;
      dec_row   = row_q;
      dec_score = left_q;
    end
    dec_last = is_terminal(dec_row, dec_col, dec_score, lmode_q);
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state. EMIT routes the next cell itself (it is known non-terminal
  // there), skipping CHK to keep 6 cycles per interior and 2 per boundary step.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = start_oor ? StFin : StRdC;
        end
      end
      StRdC: state_d = StChk;
      StChk: begin
        if (chk_term) begin
          state_d = StFin;
        end else if (chk_bound) begin
          state_d = StDecide;
        end else begin
          state_d = StRdD;
        end
      end
      StRdD:    state_d = StRdT;
      StRdT:    state_d = StRdL;
      StRdL:    state_d = StCap;
      StCap:    state_d = StDecide;
      StDecide: state_d = StEmit;
      StEmit: begin
        if (op.op_ready) begin
          if (last_q) begin
            state_d = StFin;
          end else if (next_bound) begin
            state_d = StDecide;
          end else begin
            state_d = StRdD;
          end
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs: status, RAM strobe/address and the op stream.
  always_comb begin
    busy      = (state_q != StIdle) && (state_q != StFin);
    done      = (state_q == StFin);
    err       = err_q;
    op_count  = cnt_q;
    mem_rd_en = (state_q == StRdC) || (state_q == StRdD) ||
                (state_q == StRdT) || (state_q == StRdL);
    addr_row  = row_q;
    addr_col  = col_q;
    unique case (state_q)
      StRdD: begin
        addr_row = row_q - IDX_W'(1);
        addr_col = col_q - IDX_W'(1);
      end
      StRdT:   addr_row = row_q - IDX_W'(1);
      StRdL:   addr_col = col_q - IDX_W'(1);
      default: ;
    endcase
    mem_addr    = mem_rd_en ? (ADDR_W'(addr_row) * ADDR_W'(COLS) + ADDR_W'(addr_col)) : '0;
    op.op_valid = (state_q == StEmit);
    op.op_code  = op.op_valid ? code_q : 2'b00;
    op.op_row   = op.op_valid ? orow_q : '0;
    op.op_col   = op.op_valid ? ocol_q : '0;
    op.op_last  = op.op_valid && last_q;
  end

  // Datapath: coordinates, captured scores, pending op and result counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q    <= '0;
      col_q    <= '0;
      lmode_q  <= 1'b0;
      cur_q    <= '0;
      diag_q   <= '0;
      top_q    <= '0;
      left_q   <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      code_q   <= OpDiag;
      orow_q   <= '0;
      ocol_q   <= '0;
      last_q   <= 1'b0;
      nrow_q   <= '0;
      ncol_q   <= '0;
      nscore_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            row_q   <= start_row;
            col_q   <= start_col;
            lmode_q <= local_mode;
            err_q   <= start_oor;
            cnt_q   <= '0;
          end
        end
        StChk: cur_q  <= mem_rdata;
        StRdT: diag_q <= mem_rdata;
        StRdL: top_q  <= mem_rdata;
        StCap: left_q <= mem_rdata;
        StDecide: begin
          code_q   <= dec_code;
          orow_q   <= row_q;
          ocol_q   <= col_q;
          last_q   <= dec_last;
          nrow_q   <= dec_row;
          ncol_q   <= dec_col;
          nscore_q <= dec_score;
        end
        StEmit: begin
          if (op.op_ready) begin
            row_q <= nrow_q;
            col_q <= ncol_q;
            cur_q <= nscore_q;
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_traceback_engine.sv
// Directed bench for traceback_engine on a 4x4 matrix with a scoreboard of expected ops.
module tb_traceback_engine;

  localparam int N = 4;

  typedef struct packed {
    logic [1:0] code;
    logic [3:0] row;
    logic [3:0] col;
    logic       last;
  } op_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [3:0]         start_row, start_col;
  logic               local_mode;
  logic               busy, done, err;
  logic [4:0]         op_count;
  logic               mem_rd_en;
  logic [3:0]         mem_addr;
  logic signed [15:0] mem_rdata = '0;
  logic signed [15:0] mem [N*N];

  int  n_chk  = 0;
  int  n_fail = 0;
  op_t exp_q[$];
  op_t e_op, g_op;

  traceback_engine_if #(.IDX_W(4)) opif ();

  traceback_engine #(
    .ROWS(N), .COLS(N), .SCORE_W(16), .ADDR_W(4), .IDX_W(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_row  (start_row),
    .start_col  (start_col),
    .local_mode (local_mode),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .op_count   (op_count),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .op         (opif.master)
  );

  always #5 clk = ~clk;

  // Synchronous RAM with one cycle of read latency.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every accepted op is popped and compared.
  always @(negedge clk) begin
    #1;
    if (opif.op_valid === 1'b1 && opif.op_ready === 1'b1) begin
      g_op = '{code: opif.op_code, row: opif.op_row, col: opif.op_col, last: opif.op_last};
      n_chk++;
      assert (exp_q.size() > 0) else begin
        n_fail++;
        $error("FAIL op_extra: observed op %0d@(%0d,%0d) last=%0d expected none",
               g_op.code, g_op.row, g_op.col, g_op.last);
      end
      if (exp_q.size() > 0) begin
        e_op = exp_q.pop_front();
        n_chk++;
        assert (g_op === e_op) else begin
          n_fail++;
          $error("FAIL op: observed %0d@(%0d,%0d) last=%0d expected %0d@(%0d,%0d) last=%0d",
                 g_op.code, g_op.row, g_op.col, g_op.last,
                 e_op.code, e_op.row, e_op.col, e_op.last);
        end
      end
    end
  end

  task automatic fill(input logic signed [15:0] v);
    for (int i = 0; i < N*N; i++) mem[i] = v;
  endtask

  task automatic setc(input int r, input int c, input logic signed [15:0] v);
    mem[r*N+c] = v;
  endtask

  task automatic push(input logic [1:0] code, input int r, input int c, input logic last);
    exp_q.push_back('{code: code, row: 4'(r), col: 4'(c), last: last});
  endtask

  task automatic pulse_start(input int r, input int c, input logic lm);
    @(negedge clk);
    start_row  = 4'(r);
    start_col  = 4'(c);
    local_mode = lm;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  // Bounded wait for done; counts cycles and read strobes on the way.
  task automatic wait_done(output int cyc, output int rds, output bit bsy);
    cyc = 0;
    rds = 0;
    bsy = 1'b0;
    while (done !== 1'b1 && cyc < 300) begin
      if (mem_rd_en === 1'b1) rds++;
      if (busy === 1'b1) bsy = 1'b1;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic end_checks(input string tag, input int cnt, input logic e);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_count"}, 32'(op_count), 32'(cnt));
    check({tag, "_err"}, 32'(err), 32'(e));
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    check({tag, "_done_pulse"}, {30'd0, done, busy}, 32'd0);
    exp_q.delete();
  endtask

  task automatic run(input string tag, input int r, input int c, input logic lm,
                     input int cnt, input logic e, output int cyc, output int rds);
    bit bsy;
    pulse_start(r, c, lm);
    wait_done(cyc, rds, bsy);
    if (!e) check({tag, "_busy"}, 32'(bsy), 32'd1);
    end_checks(tag, cnt, e);
  endtask

  task automatic diag_matrix();
    fill(-16'sd9);
    setc(0, 0, 16'sd0);
    setc(1, 1, 16'sd3);
    setc(2, 2, 16'sd6);
    setc(3, 3, 16'sd9);
  endtask

  initial begin
    int cyc, rds, k;
    bit bsy;
    rst          = 1'b1;
    start        = 1'b0;
    start_row    = '0;
    start_col    = '0;
    local_mode   = 1'b0;
    opif.op_ready = 1'b1;
    fill(-16'sd9);
    #2;
    check("reset_outputs", {7'd0, busy, done, err, op_count, mem_rd_en, mem_addr, opif.op_valid,
                            opif.op_code, opif.op_row, opif.op_col, opif.op_last}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Global diagonal walk.
    diag_matrix();
    push(2'b00, 3, 3, 1'b0);
    push(2'b00, 2, 2, 1'b0);
    push(2'b00, 1, 1, 1'b1);
    run("diag", 3, 3, 1'b0, 3, 1'b0, cyc, rds);
    check("diag_cycles", 32'(cyc), 32'd20);
    check("diag_reads", 32'(rds), 32'd10);

    // Three-way tie goes diag.
    fill(-16'sd9);
    setc(0, 0, 16'sd0);
    setc(1, 1, 16'sd5);
    setc(1, 2, 16'sd5);
    setc(2, 1, 16'sd5);
    setc(2, 2, 16'sd7);
    push(2'b00, 2, 2, 1'b0);
    push(2'b00, 1, 1, 1'b1);
    run("tie3", 2, 2, 1'b0, 2, 1'b0, cyc, rds);

    // Top/left tie beats a smaller diag and goes top.
    fill(-16'sd9);
    setc(0, 0, 16'sd0);
    setc(1, 1, 16'sd4);
    setc(1, 2, 16'sd6);
    setc(2, 1, 16'sd6);
    push(2'b01, 2, 2, 1'b0);
    push(2'b10, 1, 2, 1'b0);
    push(2'b00, 1, 1, 1'b1);
    run("tie_top", 2, 2, 1'b0, 3, 1'b0, cyc, rds);

    // Global boundary walks: no reads beyond the start cell.
    fill(-16'sd9);
    push(2'b10, 0, 3, 1'b0);
    push(2'b10, 0, 2, 1'b0);
    push(2'b10, 0, 1, 1'b1);
    run("row0", 0, 3, 1'b0, 3, 1'b0, cyc, rds);
    check("row0_reads", 32'(rds), 32'd1);
    check("row0_cycles", 32'(cyc), 32'd8);
    push(2'b01, 3, 0, 1'b0);
    push(2'b01, 2, 0, 1'b0);
    push(2'b01, 1, 0, 1'b1);
    run("col0", 3, 0, 1'b0, 3, 1'b0, cyc, rds);
    check("col0_reads", 32'(rds), 32'd1);

    // Out-of-range starts.
    run("oor_row", 9, 1, 1'b0, 0, 1'b1, cyc, rds);
    check("oor_row_latency", 32'(cyc <= 1), 32'd1);
    check("oor_row_reads", 32'(rds), 32'd0);
    run("oor_col", 2, 4, 1'b0, 0, 1'b1, cyc, rds);

    // Local mode: one diag step into a zero score, then a zero-score start.
    fill(-16'sd9);
    setc(3, 3, 16'sd4);
    setc(2, 2, 16'sd0);
    setc(2, 3, -16'sd1);
    setc(3, 2, -16'sd2);
    push(2'b00, 3, 3, 1'b1);
    run("local1", 3, 3, 1'b1, 1, 1'b0, cyc, rds);
    check("local1_reads", 32'(rds), 32'd4);
    check("local1_cycles", 32'(cyc), 32'd8);
    setc(3, 3, 16'sd0);
    run("local0", 3, 3, 1'b1, 0, 1'b0, cyc, rds);
    check("local0_cycles", 32'(cyc), 32'd2);
    check("local0_reads", 32'(rds), 32'd1);
    setc(0, 2, 16'sd5);
    run("local_row0", 0, 2, 1'b1, 0, 1'b0, cyc, rds);
    run("origin", 0, 0, 1'b0, 0, 1'b0, cyc, rds);

    // Backpressure on the first op, with a start pulse that must be ignored.
    diag_matrix();
    push(2'b00, 3, 3, 1'b0);
    push(2'b00, 2, 2, 1'b0);
    push(2'b00, 1, 1, 1'b1);
    opif.op_ready = 1'b0;
    pulse_start(3, 3, 1'b0);
    k = 0;
    while (opif.op_valid !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("stall_valid_seen", 32'(opif.op_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        start_row = 4'd0;
        start_col = 4'd3;
        start     = 1'b1;
      end else begin
        start     = 1'b0;
      end
      @(negedge clk);
      check("stall_hold", {20'd0, opif.op_valid, opif.op_code, opif.op_row, opif.op_col,
                           opif.op_last, mem_rd_en}, {20'd0, 1'b1, 2'b00, 4'd3, 4'd3, 1'b0, 1'b0});
    end
    start = 1'b0;
    opif.op_ready = 1'b1;
    wait_done(cyc, rds, bsy);
    end_checks("stall", 3, 1'b0);

    // Reset while an op is pending abandons the walk.
    diag_matrix();
    push(2'b00, 3, 3, 1'b0);
    opif.op_ready = 1'b0;
    pulse_start(3, 3, 1'b0);
    k = 0;
    while (opif.op_valid !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("rst_valid_seen", 32'(opif.op_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_outputs", {7'd0, busy, done, err, op_count, mem_rd_en, mem_addr, opif.op_valid,
                          opif.op_code, opif.op_row, opif.op_col, opif.op_last}, 32'd0);
    exp_q.delete();
    opif.op_ready = 1'b1;
    @(negedge clk);
    check("rst_no_done", 32'(done), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_idle", {30'd0, done, busy}, 32'd0);

    push(2'b00, 3, 3, 1'b0);
    push(2'b00, 2, 2, 1'b0);
    push(2'b00, 1, 1, 1'b1);
    run("after_rst", 3, 3, 1'b0, 3, 1'b0, cyc, rds);
    check("after_rst_cycles", 32'(cyc), 32'd20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
